// File: rtl/dbram_pkg.sv
// Shared constants and the parity helper for the ping-pong buffer.
// The parity helper is only used when DBRAM_PARITY_EN is defined.
package dbram_pkg;

    localparam int NUM_BANKS = 2;
    localparam int FILL_W    = 2;
    localparam int PAR_MAX_W = 64;

    // Even parity bit: XOR of all data bits, so data plus parity has an even count of ones.
    // Narrower data words are zero-extended by the caller, which leaves the result unchanged.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dbram_bank.sv
// One bank of the ping-pong buffer: write port A, registered read port B, 1-cycle read latency.
// With SIMULATION_MEMORY defined it is a behavioural array; otherwise it wraps dual_port_ram.
module dbram_bank #(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096,
    parameter int WIDTH     = 40
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

`ifdef SIMULATION_MEMORY
    logic [WIDTH-1:0] mem [NUM_WORDS];

    // Behavioural RAM with the same timing as the primitive.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`else
    dual_port_ram #(
        .AWIDTH (AWIDTH),
        .DEPTH  (NUM_WORDS),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clk   (clk),
        .wea   (wr_en),
        .addra (wr_addr),
        .dina  (wr_data),
        .enb   (rd_en),
        .addrb (rd_addr),
        .doutb (rd_data)
    );
`endif

endmodule

// File: rtl/dual_port_ram.sv
// Generic simple dual-port RAM primitive: synchronous write port A, registered read port B.
// This is the stand-in for the technology macro.
module dual_port_ram #(
    parameter int AWIDTH = 12,
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 40
) (
    input  logic              clk,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [WIDTH-1:0]  dina,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [WIDTH-1:0]  doutb
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset, as a RAM macro would be.
    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/dbram_pingpong_ctrl.sv
// Double-buffered RAM with producer/consumer ownership handshake (commit / release).
// Optional macro DBRAM_PARITY_EN adds a stored even-parity bit and rd_par_err checking.
module dbram_pingpong_ctrl
    import dbram_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096,
    parameter int DWIDTH    = 40
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_avail,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        fill_cnt,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              rd_par_err
);

`ifdef DBRAM_PARITY_EN
    localparam int BW = DWIDTH + 1;
`else
    localparam int BW = DWIDTH;
`endif

    logic              wr_sel_q,   wr_sel_d;
    logic              rd_sel_q,   rd_sel_d;
    logic              rd_bank_q,  rd_bank_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;
    logic [FILL_W-1:0] fill_q,     fill_d;

    logic              full_s;
    logic              empty_s;
    logic              wr_ok_s;
    logic              commit_ok_s;
    logic              rd_ok_s;
    logic              release_ok_s;
    logic [BW-1:0]     wr_word_s;
    logic [BW-1:0]     rd_word_s;
    logic [BW-1:0]     bank_dout_s [NUM_BANKS];

    assign full_s       = (fill_q == 2'd2);
    assign empty_s      = (fill_q == 2'd0);
    assign wr_ok_s      = wr_en      && !full_s;
    assign commit_ok_s  = wr_commit  && !full_s;
    assign rd_ok_s      = rd_en      && !empty_s;
    assign release_ok_s = rd_release && !empty_s;

    // Next-state logic for ownership pointers, fill level, read pipeline and sticky errors.
    always_comb begin
        wr_sel_d   = wr_sel_q ^ commit_ok_s;
        rd_sel_d   = rd_sel_q ^ release_ok_s;
        rd_valid_d = rd_ok_s;
        ovf_d      = ovf_q | (full_s  && (wr_en || wr_commit));
        unf_d      = unf_q | (empty_s && (rd_en || rd_release));
        if (rd_ok_s) begin
            rd_bank_d = rd_sel_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
        case ({commit_ok_s, release_ok_s})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // State registers; an asynchronous reset also kills any in-flight read beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            fill_q     <= 2'd0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_bank_q  <= rd_bank_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            fill_q     <= fill_d;
        end
    end

`ifdef DBRAM_PARITY_EN
    assign wr_word_s = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
`else
    assign wr_word_s = wr_data;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dbram_bank #(
            .AWIDTH    (AWIDTH),
            .NUM_WORDS (NUM_WORDS),
            .WIDTH     (BW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_ok_s && (wr_sel_q == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_word_s),
            .rd_en   (rd_ok_s && (rd_sel_q == 1'(b))),
            .rd_addr (rd_addr),
            .rd_data (bank_dout_s[b])
        );
    end

    // The bank captured at accept time, not the live rd_sel, so a same-cycle release is harmless.
    assign rd_word_s = bank_dout_s[rd_bank_q];

    assign wr_avail = !full_s;
    assign rd_avail = !empty_s;
    assign fill_cnt = fill_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? rd_word_s[DWIDTH-1:0] : {DWIDTH{1'b0}};

`ifdef DBRAM_PARITY_EN
    assign rd_par_err = rd_valid_q &&
                        (even_parity(PAR_MAX_W'(rd_word_s[DWIDTH-1:0])) != rd_word_s[DWIDTH]);
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: doc/dbram_pingpong_ctrl.md
Name: dbram_pingpong_ctrl

Overview:
- Parametrised double-buffered (ping-pong) RAM: two banks of NUM_WORDS x DWIDTH, each a simple dual-port RAM.
- Bank ownership is managed by an internal producer/consumer handshake rather than a free-running toggle.
- The producer fills one bank while the consumer drains the other. Banks swap on explicit commit/release.
- Used between layer stages in the accelerator datapath: activation buffers and weight staging.

Parameters:
- AWIDTH, 12, word address width per bank
- NUM_WORDS, 4096, words per bank (≤ 2^AWIDTH)
- DWIDTH, 40, data word width

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous reset, active-low
- wr_en  in  1  write request, producer side
- wr_addr  in  AWIDTH  write address within the producer's bank
- wr_data  in  DWIDTH  write data
- wr_commit  in  1  producer marks its current bank full
- wr_avail  out  1  producer owns a writable bank (fill_cnt<2)
- rd_en  in  1  read request, consumer side
- rd_addr  in  AWIDTH  read address within the consumer's bank
- rd_release  in  1  consumer marks its current bank consumed
- rd_avail  out  1  a full bank is readable (fill_cnt>0)
- rd_data  out  DWIDTH  read data; 0 whenever rd_valid=0
- rd_valid  out  1  rd_data valid, 1 cycle after an accepted rd_en
- fill_cnt  out  2  number of full banks, 0..2
- ovf_err  out  1  sticky: write or commit attempted while fill_cnt==2
- unf_err  out  1  sticky: read or release attempted while fill_cnt==0
- rd_par_err  out  1  parity mismatch on the current rd_valid beat (optional feature)

Behaviour:
- State registers: wr_sel, rd_sel (1 bit each), fill_cnt (2 bits), ovf_err, unf_err, rd_valid, rd_sel_q.
- Reset:
  - All state registers clear to 0 asynchronously; outputs are therefore wr_avail=1, rd_avail=0, rd_valid=0, rd_data=0, errors=0.
  - RAM contents are not reset.
- Write:
  - Accepted when wr_en && fill_cnt!=2: bank[wr_sel][wr_addr] <= wr_data.
  - When fill_cnt==2 the write is dropped and ovf_err is set.
- Commit:
  - When fill_cnt!=2: wr_sel toggles and fill_cnt increments.
  - When fill_cnt==2: ignored, ovf_err is set.
  - A write in the same cycle as a commit lands in the pre-toggle bank.
- Read:
  - Accepted when rd_en && fill_cnt!=0: bank[rd_sel][rd_addr] is read.
  - rd_valid=1 on the next cycle, with rd_data taken from the bank latched in rd_sel_q.
  - When fill_cnt==0 the read is dropped: no rd_valid, and unf_err is set.
  - Back-to-back reads give full throughput.
- Release:
  - When fill_cnt!=0: rd_sel toggles and fill_cnt decrements.
  - When fill_cnt==0: ignored, unf_err is set.
  - A read in the same cycle as a release reads the pre-toggle bank; its data returns the next cycle and is still correct.
- Simultaneous commit and release (both legal): both pointers toggle and fill_cnt is unchanged.
- Bank conflicts:
  - By construction wr_sel==rd_sel only when fill_cnt is 0 or 2. In those states the blocked side cannot access the RAM, so a port never reads and writes the same bank in the same cycle.
- Address range: addresses ≥ NUM_WORDS are undefined usage; no checking is done.
- Sticky errors: cleared only by resetn.
- Reset mid-operation: any in-flight rd_valid is killed and both banks are logically emptied.

Optional Feature:
- Macro: DBRAM_PARITY_EN.
- When defined:
  - Each bank stores DWIDTH+1 bits; the extra bit is the even parity of wr_data.
  - On each rd_valid beat, rd_par_err = (recomputed parity != stored parity).
  - rd_par_err is 0 when rd_valid=0.
- When undefined: banks store DWIDTH bits, rd_par_err is tied to 0, and the port stays present.

Decomposition:
- Package dbram_pkg:
  - NUM_BANKS=2 constant.
  - FILL_W=2 constant.
  - Even-parity function over DWIDTH bits.
- Sub-module dbram_bank:
  - One simple dual-port RAM: write port A, registered read port B, 1-cycle latency.
  - Under SIMULATION_MEMORY it is a behavioural array; otherwise it instantiates the dual_port_ram primitive.
  - Instantiated twice.

Test Plan:
- Reset, fill, drain:
  - Release resetn, then write addr 0..3 with data 0xA0..0xA3, then commit.
  - Expect fill_cnt=1, rd_avail=1.
  - Read addr 0..3: rd_valid on cycles +1..+4 with rd_data 0xA0..0xA3. Release; expect fill_cnt=0.
- Ping-pong overlap:
  - While the consumer reads bank 0 (data 0x11), the producer writes bank 1 with 0x22 at the same addresses.
  - Commit and release on the same cycle: fill_cnt stays 1.
  - Subsequent reads return 0x22; no errors.
- Overflow:
  - Commit twice (fill_cnt=2), then wr_en to addr 5 with data 0xFF, then commit again.
  - Expect: write dropped, ovf_err=1, fill_cnt=2, wr_avail=0.
  - Later reads of addr 5 return the original contents.
- Underflow:
  - After reset, assert rd_en and rd_release.
  - Expect rd_valid=0, rd_data=0, unf_err=1, fill_cnt=0.
- Reset mid-read:
  - Accept rd_en, then assert resetn=0 before the next edge.
  - Expect rd_valid=0 immediately, fill_cnt=0, errors cleared.
- Parity (DBRAM_PARITY_EN defined):
  - Write 0x0000000001, then force-flip bit 0 in the bank array.
  - The read returns rd_par_err=1 alongside rd_valid. Without the macro, rd_par_err stays 0.
